// File: rtl/aes_dec_arbiter.sv
// Round-robin arbiter sharing one AES-192 decrypt core between NREQ requesters.
// Define AES_DEC_ARB_STATS_EN to add per-requester issue counters and in-flight count.
module aes_dec_arbiter #(
   parameter int NREQ      = 2,
   parameter int TAG_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ*128-1:0]       req_ct,
   input  logic [NREQ-1:0]           req_vld,
   output logic [NREQ-1:0]           req_rdy,
   output logic [127:0]              rsp_pt,
   output logic [NREQ-1:0]           rsp_vld,
   output logic [127:0]              core_ct,
   output logic                      core_ct_vld,
   input  logic                      core_ct_rdy,
   input  logic [127:0]              core_pt,
   input  logic                      core_pt_vld,
   output logic                      tag_err
`ifdef AES_DEC_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]        stat_issued,
   output logic [$clog2(TAG_DEPTH):0] stat_inflight
`endif
);
   localparam int IW = $clog2(NREQ);
   localparam int AW = $clog2(TAG_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(TAG_DEPTH);

   typedef enum logic {S_IDLE, S_OFFER} state_t;
   state_t r_state, w_state_nxt;

   logic [IW-1:0]   r_ptr, r_g, w_g;
   logic            w_any, w_grant, w_push, w_pop, w_orphan;
   logic [IW-1:0]   r_tag [TAG_DEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [AW:0]     r_cnt;
   logic [NREQ-1:0] r_rsp_vld;
   logic [127:0]    r_rsp_pt, r_core_ct;
   logic            r_err;

   // Scan downward so the lowest offset from the pointer wins.
   always_comb begin
      w_any = 1'b0;
      w_g   = r_ptr;
      for (int k = NREQ-1; k >= 0; k--) begin
         int j;
         j = int'(r_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req_vld[j]) begin
            w_any = 1'b1;
            w_g   = IW'(j);
         end
      end
   end

   assign w_grant  = rst && (r_state == S_IDLE) && w_any && (r_cnt < FULL);
   assign w_push   = (r_state == S_OFFER) && core_ct_rdy;
   assign w_pop    = core_pt_vld && (r_cnt != '0);
   assign w_orphan = core_pt_vld && (r_cnt == '0) && !w_push;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_rdy     = '0;
      core_ct_vld = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               req_rdy[w_g] = 1'b1;
               w_state_nxt  = S_OFFER;
            end
         end
         S_OFFER: begin
            core_ct_vld = 1'b1;
            if (core_ct_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_tag[r_wp] <= r_g;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr     <= '0;
         r_g       <= '0;
         r_core_ct <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_rsp_vld <= '0;
         r_rsp_pt  <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_grant) begin
            r_g       <= w_g;
            r_core_ct <= req_ct[int'(w_g)*128 +: 128];
         end
         if (w_push) begin
            r_wp  <= r_wp + AW'(1);
            r_ptr <= (r_g == IW'(NREQ-1)) ? '0 : r_g + IW'(1);
         end
         r_rsp_vld <= '0;
         if (w_pop) begin
            r_rp                   <= r_rp + AW'(1);
            r_rsp_vld[r_tag[r_rp]] <= 1'b1;
            r_rsp_pt               <= core_pt;
         end
         if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
         if (w_orphan) r_err <= 1'b1;
      end
   end

   assign core_ct = r_core_ct;
   assign rsp_vld = r_rsp_vld;
   assign rsp_pt  = r_rsp_pt;
   assign tag_err = r_err;

`ifdef AES_DEC_ARB_STATS_EN
   logic [15:0] r_stat [NREQ];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) r_stat[i] <= '0;
      end else if (w_push && (r_stat[r_g] != 16'hFFFF)) begin
         r_stat[r_g] <= r_stat[r_g] + 16'd1;
      end
   end

   always_comb begin
      stat_issued = '0;
      for (int i = 0; i < NREQ; i++) stat_issued[i*16 +: 16] = r_stat[i];
   end

   assign stat_inflight = r_cnt;
`endif

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed bench for aes_dec_arbiter (NREQ=2, TAG_DEPTH=4).
// Drives the core handshake by hand and checks grants, tags and errors.
module tb_aes_dec_arbiter;
   localparam int NREQ = 2;
   localparam int TD   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ*128-1:0] req_ct;
   logic [NREQ-1:0]     req_vld;
   logic [NREQ-1:0]     req_rdy;
   logic [127:0]        rsp_pt;
   logic [NREQ-1:0]     rsp_vld;
   logic [127:0]        core_ct;
   logic                core_ct_vld;
   logic                core_ct_rdy;
   logic [127:0]        core_pt;
   logic                core_pt_vld;
   logic                tag_err;

   int n_chk  = 0;
   int n_fail = 0;

   aes_dec_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_ct      (req_ct),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .rsp_pt      (rsp_pt),
      .rsp_vld     (rsp_vld),
      .core_ct     (core_ct),
      .core_ct_vld (core_ct_vld),
      .core_ct_rdy (core_ct_rdy),
      .core_pt     (core_pt),
      .core_pt_vld (core_pt_vld),
      .tag_err     (tag_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] ptv(input int i);
      return 128'hBEEF_0000 + 128'(i);
   endfunction

   initial begin
      logic [1:0] exp_g;
      logic [1:0] exp_r [3];
      exp_r[0] = 2'b01;
      exp_r[1] = 2'b10;
      exp_r[2] = 2'b01;

      rst         = 1'b0;
      req_vld     = 2'b11;
      req_ct      = {128'h2, 128'h1};
      core_ct_rdy = 1'b0;
      core_pt_vld = 1'b0;
      core_pt     = '0;
      step;
      step;
      #1;
      chk("rst_rdy",    128'(req_rdy),     128'(2'b00));
      chk("rst_rspv",   128'(rsp_vld),     128'(2'b00));
      chk("rst_rsppt",  rsp_pt,            128'h0);
      chk("rst_ct",     core_ct,           128'h0);
      chk("rst_ctvld",  128'(core_ct_vld), 128'(1'b0));
      chk("rst_err",    128'(tag_err),     128'(1'b0));

      // fairness: both requesters valid, core always ready
      rst         = 1'b1;
      core_ct_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         chk("rr_grant",  128'(req_rdy),     128'(exp_g));
         chk("rr_idlev",  128'(core_ct_vld), 128'(1'b0));
         step;
         chk("rr_offv",   128'(core_ct_vld), 128'(1'b1));
         chk("rr_ct",     core_ct, (k % 2 == 0) ? 128'h1 : 128'h2);
         chk("rr_offrdy", 128'(req_rdy),     128'(2'b00));
         step;
      end
      #1;
      chk("full_rdy", 128'(req_rdy), 128'(2'b00));
      step;

      // one pop frees a slot; the next grant follows
      req_vld             = 2'b01;
      req_ct[0 +: 128]    = 128'h3333;
      core_ct_rdy         = 1'b0;
      core_pt_vld         = 1'b1;
      core_pt             = ptv(0);
      #1;
      chk("full_rdy2", 128'(req_rdy), 128'(2'b00));
      step;
      core_pt_vld = 1'b0;
      #1;
      chk("pop0_vld",  128'(rsp_vld), 128'(2'b01));
      chk("pop0_pt",   rsp_pt,        ptv(0));
      chk("grant5",    128'(req_rdy), 128'(2'b01));
      step;

      // backpressure: seven stalled cycles
      req_ct[0 +: 128] = 128'h4444;
      for (int s = 0; s < 7; s++) begin
         #1;
         chk("stall_vld", 128'(core_ct_vld), 128'(1'b1));
         chk("stall_ct",  core_ct,           128'h3333);
         chk("stall_rdy", 128'(req_rdy),     128'(2'b00));
         chk("stall_rsp", 128'(rsp_vld),     128'(2'b00));
         step;
      end

      // simultaneous push and pop
      core_ct_rdy = 1'b1;
      core_pt_vld = 1'b1;
      core_pt     = ptv(1);
      #1;
      chk("pp_vld", 128'(core_ct_vld), 128'(1'b1));
      step;
      core_ct_rdy = 1'b0;
      core_pt_vld = 1'b0;
      req_vld     = 2'b00;
      #1;
      chk("pp_rsp",   128'(rsp_vld),     128'(2'b10));
      chk("pp_pt",    rsp_pt,            ptv(1));
      chk("pp_ctvld", 128'(core_ct_vld), 128'(1'b0));
      step;

      // drain: old 0, old 1, then the pushed 0
      for (int j = 0; j < 3; j++) begin
         core_pt_vld = 1'b1;
         core_pt     = ptv(2 + j);
         step;
         #1;
         chk("drain_vld", 128'(rsp_vld), 128'(exp_r[j]));
         chk("drain_pt",  rsp_pt,        ptv(2 + j));
      end
      core_pt_vld = 1'b0;
      step;
      #1;
      chk("drain_end",  128'(rsp_vld), 128'(2'b00));
      chk("hold_pt",    rsp_pt,        ptv(4));
      chk("no_err",     128'(tag_err), 128'(1'b0));

      // orphan plaintext
      core_pt_vld = 1'b1;
      core_pt     = ptv(9);
      step;
      core_pt_vld = 1'b0;
      #1;
      chk("orph_rsp", 128'(rsp_vld), 128'(2'b00));
      chk("orph_err", 128'(tag_err), 128'(1'b1));
      chk("orph_pt",  rsp_pt,        ptv(4));
      step;
      step;
      #1;
      chk("orph_hold", 128'(tag_err), 128'(1'b1));

      // three blocks in flight from requester 0, then reset
      req_vld          = 2'b01;
      req_ct[0 +: 128] = 128'h5555;
      core_ct_rdy      = 1'b1;
      for (int c = 0; c < 6; c++) step;
      req_vld = 2'b11;
      rst     = 1'b0;
      #1;
      chk("mr_rdy0", 128'(req_rdy), 128'(2'b00));
      step;
      rst = 1'b1;
      #1;
      chk("mr_err",   128'(tag_err),     128'(1'b0));
      chk("mr_ct",    core_ct,           128'h0);
      chk("mr_ctvld", 128'(core_ct_vld), 128'(1'b0));
      chk("mr_rsp",   128'(rsp_vld),     128'(2'b00));
      chk("mr_pt",    rsp_pt,            128'h0);
      chk("mr_grant", 128'(req_rdy),     128'(2'b01));
      step;
      req_vld = 2'b00;
      #1;
      chk("mr_offct", core_ct,           128'h5555);
      chk("mr_offv",  128'(core_ct_vld), 128'(1'b1));
      step;
      core_ct_rdy = 1'b0;
      step;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
